// File: rtl/fpga_mem_pkg.sv
// Shared types and constants for the FPGA memory responder.
package fpga_mem_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] strb_t;

  localparam int unsigned DefaultDepth = 32768;
  localparam int unsigned MaxGntDelay  = 15;
  localparam int unsigned CntWidth     = $clog2(MaxGntDelay + 1);

  // Per-bit merge: strobe bits select new data, others keep the old word.
  function automatic data_t apply_strb(data_t old_word, data_t wdata, strb_t strb);
    return (old_word & ~strb) | (wdata & strb);
  endfunction

endpackage

// File: rtl/fpga_mem_responder_ram.sv
// Single-port synchronous word array with bitwise write mask and registered read port.
module fpga_mem_responder_ram
  import fpga_mem_pkg::*;
#(
  parameter  int unsigned Depth     = DefaultDepth,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [31:0]          strb_i,
  output logic [31:0]          rdata_o
);

  data_t mem_q [Depth];
  data_t rdata_q;

  // Array deliberately has no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= apply_strb(mem_q[addr_i], wdata_i, strb_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fpga_mem_responder.sv
// Memory-side responder: grants after GntDelay stall cycles, one-cycle read latency.
// Optional access counters enabled by defining FPGA_MEM_RESPONDER_ACCESS_CNT_EN.
module fpga_mem_responder
  import fpga_mem_pkg::*;
#(
  parameter  int unsigned Depth     = DefaultDepth,
  parameter  int unsigned GntDelay  = 0,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [31:0]          strb_i,
  input  logic                 we_i,
  output logic [31:0]          rdata_o,
  output logic                 rvalid_o
`ifdef FPGA_MEM_RESPONDER_ACCESS_CNT_EN
  ,
  output logic [31:0]          rd_cnt_o,
  output logic [31:0]          wr_cnt_o
`endif
);

  localparam logic [CntWidth-1:0] GntDelayC = CntWidth'(GntDelay);

  logic [CntWidth-1:0] cnt_d, cnt_q;
  logic                rvalid_d, rvalid_q;
  logic                access;

  assign gnt_o  = req_i && (cnt_q == GntDelayC);
  // A grant coinciding with reset is dropped entirely.
  assign access = gnt_o && !rst_i;

  always_comb begin
    cnt_d = '0;
    if (req_i && !gnt_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rvalid_d = access && !we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid_o = rvalid_q;

  fpga_mem_responder_ram #(
    .Depth (Depth)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (access),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .strb_i  (strb_i),
    .rdata_o (rdata_o)
  );

`ifdef FPGA_MEM_RESPONDER_ACCESS_CNT_EN
  logic [31:0] rd_cnt_d, rd_cnt_q;
  logic [31:0] wr_cnt_d, wr_cnt_q;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (access && !we_i && (rd_cnt_q != 32'hFFFF_FFFF)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (access && we_i && (wr_cnt_q != 32'hFFFF_FFFF)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_fpga_mem_responder.sv
// Scoreboard bench: instance 0 with GntDelay=0, instance 1 with GntDelay=3.
module tb_fpga_mem_responder;

  localparam int AW = 15;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt, we, rvalid;
  logic [AW-1:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] strb [2];
  logic [31:0] rdata [2];
`ifdef FPGA_MEM_RESPONDER_ACCESS_CNT_EN
  logic [31:0] rd_cnt [2];
  logic [31:0] wr_cnt [2];
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpga_mem_responder #(
    .GntDelay (0)
  ) u_dut0 (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req[0]),
    .gnt_o    (gnt[0]),
    .addr_i   (addr[0]),
    .wdata_i  (wdata[0]),
    .strb_i   (strb[0]),
    .we_i     (we[0]),
    .rdata_o  (rdata[0]),
    .rvalid_o (rvalid[0])
`ifdef FPGA_MEM_RESPONDER_ACCESS_CNT_EN
    ,
    .rd_cnt_o (rd_cnt[0]),
    .wr_cnt_o (wr_cnt[0])
`endif
  );

  fpga_mem_responder #(
    .GntDelay (3)
  ) u_dut1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req[1]),
    .gnt_o    (gnt[1]),
    .addr_i   (addr[1]),
    .wdata_i  (wdata[1]),
    .strb_i   (strb[1]),
    .we_i     (we[1]),
    .rdata_o  (rdata[1]),
    .rvalid_o (rvalid[1])
`ifdef FPGA_MEM_RESPONDER_ACCESS_CNT_EN
    ,
    .rd_cnt_o (rd_cnt[1]),
    .wr_cnt_o (wr_cnt[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int u, input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Issue one request and hold it until granted; reads enqueue their expected data.
  task automatic access(input int u, input logic w, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [31:0] s,
                        input int exp_lat, input logic [31:0] exp_rd);
    int n;
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d; strb[u] = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[u] && n < 50);
    chk($sformatf("gnt_latency_u%0d_a%h", u, a), 32'(n), 32'(exp_lat));
    if (gnt[u] && !w) push(u, exp_rd, cyc + 1);
    @(posedge clk);
    #1;
    req[u] = 1'b0;
  endtask

  task automatic mon(input int u, input logic rv, input logic [31:0] rd);
    exp_t e;
    int   have;
    have = (u == 0) ? q0.size() : q1.size();
    if (have > 0) e = (u == 0) ? q0[0] : q1[0];
    if (rv) begin
      if (have == 0) begin
        chk($sformatf("rvalid_unexpected_u%0d", u), 32'(rv), 32'(have));
      end else begin
        if (u == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        chk($sformatf("rdata_u%0d", u), rd, e.data);
        chk($sformatf("rvalid_cycle_u%0d", u), 32'(cyc), 32'(e.cyc));
      end
    end else if (have > 0 && e.cyc < cyc) begin
      chk($sformatf("rvalid_missing_u%0d", u), 32'(rv), 32'd1);
      if (u == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(0, rvalid[0], rdata[0]);
    mon(1, rvalid[1], rdata[1]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    we  = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0; strb[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_gnt_u%0d", i), 32'(gnt[i]), 32'd0);
      chk($sformatf("reset_rvalid_u%0d", i), 32'(rvalid[i]), 32'd0);
      chk($sformatf("reset_rdata_u%0d", i), rdata[i], 32'd0);
`ifdef FPGA_MEM_RESPONDER_ACCESS_CNT_EN
      chk($sformatf("reset_rdcnt_u%0d", i), rd_cnt[i], 32'd0);
      chk($sformatf("reset_wrcnt_u%0d", i), wr_cnt[i], 32'd0);
`endif
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // GntDelay=0: full write then read.
    access(0, 1'b1, 15'h0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, 32'h0);
    access(0, 1'b0, 15'h0010, 32'h0,         32'h0,         1, 32'hDEAD_BEEF);
    // Partial strobe at the top address.
    access(0, 1'b1, 15'h7FFF, 32'h1122_3344, 32'hFFFF_FFFF, 1, 32'h0);
    access(0, 1'b1, 15'h7FFF, 32'hAABB_CCDD, 32'h0000_FFFF, 1, 32'h0);
    access(0, 1'b0, 15'h7FFF, 32'h0,         32'h0,         1, 32'h1122_CCDD);
    // Back-to-back with req held continuously.
    access(0, 1'b1, 15'h0006, 32'h0000_0002, 32'hFFFF_FFFF, 1, 32'h0);
    access(0, 1'b1, 15'h0005, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0);
    access(0, 1'b0, 15'h0005, 32'h0,         32'h0,         1, 32'h0000_0001);
    access(0, 1'b0, 15'h0006, 32'h0,         32'h0,         1, 32'h0000_0002);

    // GntDelay=3: grant on 4th cycle of req.
    access(1, 1'b1, 15'h0001, 32'hCAFE_F00D, 32'hFFFF_FFFF, 4, 32'h0);
    access(1, 1'b0, 15'h0001, 32'h0,         32'h0,         4, 32'hCAFE_F00D);
    // Aborted write after 2 stall cycles must not touch memory.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 15'h0001;
    wdata[1] = 32'hBAD0_BAD0; strb[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_stall_gnt", 32'(gnt[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    access(1, 1'b0, 15'h0001, 32'h0, 32'h0, 4, 32'hCAFE_F00D);

    repeat (2) @(posedge clk);
`ifdef FPGA_MEM_RESPONDER_ACCESS_CNT_EN
    #1;
    chk("rdcnt_u0", rd_cnt[0], 32'd4);
    chk("wrcnt_u0", wr_cnt[0], 32'd5);
    chk("rdcnt_u1", rd_cnt[1], 32'd2);
    chk("wrcnt_u1", wr_cnt[1], 32'd1);
`endif

    // Reset during a read-grant cycle suppresses the access.
    @(posedge clk);
    #1;
    rst = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 15'h0010;
    @(negedge clk);
    chk("rst_grant_gnt", 32'(gnt[0]), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk("rst_grant_rvalid", 32'(rvalid[0]), 32'd0);
    chk("rst_grant_rdata_u0", rdata[0], 32'd0);
    chk("rst_rdata_u1", rdata[1], 32'd0);
`ifdef FPGA_MEM_RESPONDER_ACCESS_CNT_EN
    chk("rst_rdcnt_u0", rd_cnt[0], 32'd0);
`endif
    @(posedge clk);
    #1;
    access(0, 1'b0, 15'h0010, 32'h0, 32'h0, 1, 32'hDEAD_BEEF);
    access(1, 1'b0, 15'h0001, 32'h0, 32'h0, 4, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    #1;
    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
